rom_arbiter: RTL and testbench

Downstream of the address decoder. Turns decoded SNES accesses (byte address, hit, writable) and MCU byte requests into timed cycles on the shared 16-bit cartridge SRAM. SNES has fixed priority; MCU accesses fill idle bus time. Returns read bytes to the SNES data path and to the MCU.

---
 rtl/rom_arb_pkg.sv | 31 +++
 rtl/rom_arbiter_timer.sv | 34 +++
 rtl/rom_arbiter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_rom_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the cartridge SRAM arbiter.
//   arb_state_t     - arbiter FSM state encoding (also exported on state_dbg)
//   LANE_LO/LANE_HI - byte lane selected by byte address bit 0
//   DEF_*_CYCLES    - default window/gap lengths in CLK cycles
//   CNT_W           - width of the window timer
package rom_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SNES_RD = 3'd1,
    ST_SNES_WR = 3'd2,
    ST_MCU_RD  = 3'd3,
    ST_MCU_WR  = 3'd4,
    ST_GAP     = 3'd5
  } arb_state_t;

  localparam logic LANE_LO = 1'b0;  // addr[0]=0 -> D[7:0]
  localparam logic LANE_HI = 1'b1;  // addr[0]=1 -> D[15:8]

  localparam int DEF_RD_CYCLES  = 6;
  localparam int DEF_WR_CYCLES  = 5;
  localparam int DEF_GAP_CYCLES = 1;

  localparam int CNT_W = 8;

  // Byte lane of a byte address.
  function automatic logic lane_of(input logic [23:0] byte_addr);
    return byte_addr[0];
  endfunction

endpackage

// File: rtl/rom_arbiter_timer.sv
// rom_cycle_timer: loadable down-counter used to time every bus window and
// gap. Loading takes priority; otherwise it counts down and parks at zero.
//   CLK, RST  - clock, synchronous active-high reset
//   load      - load load_val this cycle
//   load_val  - window length in cycles
//   count     - current count (window cycle n of N shows N-n+1)
//   last      - count == 1, final cycle of the window
//   done      - count == 0, timer idle
module rom_cycle_timer
  import rom_arb_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             done
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));
  assign done = (count == '0);

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: turns decoded SNES accesses and MCU byte requests into timed
// read/write windows on the shared 16-bit cartridge SRAM. SNES has fixed
// priority; the MCU fills idle bus time and is never preempted mid-window.
//
// Optional feature macro: ROM_ARB_MCU_AUTOINC_EN (MCU address auto-increment).
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   snes_rd_start/snes_wr_start  one-cycle SNES access start pulses
//   snes_addr/hit/writable       decoder outputs for the access
//   snes_wr_data                 SNES write byte
//   snes_rd_data/snes_rd_valid   last SNES read byte (held) / update pulse
//   mcu_req/mcu_we/mcu_addr/mcu_wr_data   MCU request (level) and payload
//   mcu_ack/mcu_rd_data          completion pulse / read byte (held)
//   mcu_addr_cur                 address the next MCU access will use
//   ROM_*                        SRAM word address, data and strobes
//   state_dbg                    current FSM state
//
// MCU handshake: mcu_req is a level held with stable mcu_we/mcu_addr/
// mcu_wr_data until mcu_ack pulses for one cycle; the access is complete on
// that pulse. The requester drops mcu_req on the cycle after mcu_ack, and a
// request still high during the mcu_ack cycle is not treated as a new one.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int RD_CYCLES  = DEF_RD_CYCLES,
  parameter int WR_CYCLES  = DEF_WR_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        snes_rd_start,
  input  logic        snes_wr_start,
  input  logic [23:0] snes_addr,
  input  logic        snes_hit,
  input  logic        snes_writable,
  input  logic [7:0]  snes_wr_data,
  output logic [7:0]  snes_rd_data,
  output logic        snes_rd_valid,
  input  logic        mcu_req,
  input  logic        mcu_we,
  input  logic [23:0] mcu_addr,
  input  logic [7:0]  mcu_wr_data,
  output logic        mcu_ack,
  output logic [7:0]  mcu_rd_data,
  output logic [23:0] mcu_addr_cur,
  output logic [22:0] ROM_ADDR,
  output logic [15:0] ROM_DATA_OUT,
  input  logic [15:0] ROM_DATA_IN,
  output logic        ROM_DATA_OE,
  output logic        ROM_CE_n,
  output logic        ROM_OE_n,
  output logic        ROM_WE_n,
  output logic        ROM_BHE_n,
  output logic        ROM_BLE_n,
  output logic [2:0]  state_dbg
);

  arb_state_t state, state_nx;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_last;
  logic             tmr_done;

  // Current window's byte address and write byte, latched at window entry.
  logic [23:0] cur_addr;
  logic [7:0]  cur_wdata;
  logic        cur_lane;

  // One-deep SNES pending slot.
  logic        pend_valid;
  logic        pend_we;
  logic [23:0] pend_addr;
  logic [7:0]  pend_data;

  logic        snes_rd_acc, snes_wr_acc, new_acc;
  logic        snes_req, snes_req_we;
  logic [23:0] snes_req_addr;
  logic [7:0]  snes_req_data;
  logic        mcu_go;
  logic [23:0] mcu_eff_addr;

  logic arb_ok, take_snes, take_mcu, win_end;
  logic [7:0] rd_byte;

  rom_cycle_timer u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .last     (tmr_last),
    .done     (tmr_done)
  );

  // Accesses the decoder rejects never reach the pending slot. If both start
  // pulses arrive together the write is taken.
  assign snes_rd_acc = snes_rd_start & snes_hit;
  assign snes_wr_acc = snes_wr_start & snes_hit & snes_writable;
  assign new_acc     = snes_rd_acc | snes_wr_acc;

  // A start pulse bypasses the pending slot so it can be served the same
  // cycle; it also supersedes whatever the slot holds.
  assign snes_req      = new_acc | pend_valid;
  assign snes_req_we   = new_acc ? snes_wr_acc  : pend_we;
  assign snes_req_addr = new_acc ? snes_addr    : pend_addr;
  assign snes_req_data = new_acc ? snes_wr_data : pend_data;

  // mcu_ack is high exactly in the cycle after the MCU window, which is
  // when a not-yet-dropped request must be ignored.
  assign mcu_go = mcu_req & ~mcu_ack;

`ifdef ROM_ARB_MCU_AUTOINC_EN
  // The register reloads on a rising request only when the MCU presents a
  // different address than it last loaded; re-requests with an unchanged
  // mcu_addr continue the sequential stream.
  logic        mcu_req_q;
  logic [23:0] mcu_addr_reg;
  logic [23:0] mcu_base;
  logic        mcu_load;

  assign mcu_load = mcu_req & ~mcu_req_q & (mcu_addr != mcu_base);

  always_ff @(posedge CLK) begin
    if (RST) begin
      mcu_req_q    <= 1'b0;
      mcu_addr_reg <= '0;
      mcu_base     <= '0;
    end else begin
      mcu_req_q <= mcu_req;
      if (mcu_load) begin
        mcu_addr_reg <= mcu_addr;
        mcu_base     <= mcu_addr;
      end else if (mcu_ack) begin
        mcu_addr_reg <= mcu_addr_reg + 24'd1;
      end
    end
  end

  // Bypass so a request that starts in the same cycle it rises uses the
  // freshly presented address.
  assign mcu_eff_addr = mcu_load ? mcu_addr : mcu_addr_reg;
  assign mcu_addr_cur = mcu_addr_reg;
`else
  assign mcu_eff_addr = mcu_addr;
  assign mcu_addr_cur = mcu_addr;
`endif

  // Next state and timer control. Arbitration happens in IDLE and in the
  // final GAP cycle, so exactly GAP_CYCLES idle cycles separate windows
  // when work is waiting.
  always_comb begin
    state_nx  = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    take_snes = 1'b0;
    take_mcu  = 1'b0;
    win_end   = 1'b0;
    arb_ok    = 1'b0;

    case (state)
      ST_IDLE: begin
        arb_ok = 1'b1;
      end
      ST_GAP: begin
        if (tmr_last || tmr_done) begin
          arb_ok   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_SNES_RD, ST_SNES_WR, ST_MCU_RD, ST_MCU_WR: begin
        if (tmr_last) begin
          win_end = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_nx = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(GAP_CYCLES);
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    if (arb_ok) begin
      if (snes_req) begin
        take_snes = 1'b1;
        tmr_load  = 1'b1;
        state_nx  = snes_req_we ? ST_SNES_WR : ST_SNES_RD;
        tmr_val   = snes_req_we ? CNT_W'(WR_CYCLES) : CNT_W'(RD_CYCLES);
      end else if (mcu_go) begin
        take_mcu = 1'b1;
        tmr_load = 1'b1;
        state_nx = mcu_we ? ST_MCU_WR : ST_MCU_RD;
        tmr_val  = mcu_we ? CNT_W'(WR_CYCLES) : CNT_W'(RD_CYCLES);
      end
    end
  end

  assign cur_lane = lane_of(cur_addr);
  assign rd_byte  = (cur_lane == LANE_HI) ? ROM_DATA_IN[15:8] : ROM_DATA_IN[7:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      pend_valid    <= 1'b0;
      pend_we       <= 1'b0;
      pend_addr     <= '0;
      pend_data     <= '0;
      cur_addr      <= '0;
      cur_wdata     <= '0;
      snes_rd_data  <= '0;
      snes_rd_valid <= 1'b0;
      mcu_rd_data   <= '0;
      mcu_ack       <= 1'b0;
    end else begin
      state         <= state_nx;
      snes_rd_valid <= win_end && (state == ST_SNES_RD);
      mcu_ack       <= win_end && ((state == ST_MCU_RD) || (state == ST_MCU_WR));

      if (win_end && (state == ST_SNES_RD)) snes_rd_data <= rd_byte;
      if (win_end && (state == ST_MCU_RD))  mcu_rd_data  <= rd_byte;

      if (take_snes) begin
        cur_addr   <= snes_req_addr;
        cur_wdata  <= snes_req_data;
        pend_valid <= 1'b0;
      end else if (new_acc) begin
        pend_valid <= 1'b1;
        pend_we    <= snes_wr_acc;
        pend_addr  <= snes_addr;
        pend_data  <= snes_wr_data;
      end

      if (take_mcu) begin
        cur_addr  <= mcu_eff_addr;
        cur_wdata <= mcu_wr_data;
      end
    end
  end

  // Strobes decode from registered state and count only. WE_n is low from
  // window cycle 2 through WR_CYCLES-1 (count WR_CYCLES-1 down to 2),
  // leaving one cycle of address/data setup and hold around it.
  always_comb begin
    ROM_CE_n    = 1'b1;
    ROM_OE_n    = 1'b1;
    ROM_WE_n    = 1'b1;
    ROM_BHE_n   = 1'b1;
    ROM_BLE_n   = 1'b1;
    ROM_DATA_OE = 1'b0;
    case (state)
      ST_SNES_RD, ST_MCU_RD: begin
        ROM_CE_n  = 1'b0;
        ROM_OE_n  = 1'b0;
        ROM_BHE_n = 1'b0;
        ROM_BLE_n = 1'b0;
      end
      ST_SNES_WR, ST_MCU_WR: begin
        ROM_CE_n    = 1'b0;
        ROM_DATA_OE = 1'b1;
        ROM_BHE_n   = (cur_lane != LANE_HI);
        ROM_BLE_n   = (cur_lane != LANE_LO);
        ROM_WE_n    = !((tmr_count >= CNT_W'(2)) &&
                        (tmr_count <= CNT_W'(WR_CYCLES - 1)));
      end
      default: begin
      end
    endcase
  end

  assign ROM_ADDR     = cur_addr[23:1];
  assign ROM_DATA_OUT = {cur_wdata, cur_wdata};
  assign state_dbg    = state;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench for rom_arbiter with default parameters
// (RD 6, WR 5, GAP 1). Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point, when all registers have settled.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        snes_rd_start, snes_wr_start;
  logic [23:0] snes_addr;
  logic        snes_hit, snes_writable;
  logic [7:0]  snes_wr_data;
  logic [7:0]  snes_rd_data;
  logic        snes_rd_valid;
  logic        mcu_req, mcu_we;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_wr_data;
  logic        mcu_ack;
  logic [7:0]  mcu_rd_data;
  logic [23:0] mcu_addr_cur;
  logic [22:0] ROM_ADDR;
  logic [15:0] ROM_DATA_OUT;
  logic [15:0] ROM_DATA_IN;
  logic        ROM_DATA_OE, ROM_CE_n, ROM_OE_n, ROM_WE_n, ROM_BHE_n, ROM_BLE_n;
  logic [2:0]  state_dbg;

  // {CE_n, OE_n, WE_n, BHE_n, BLE_n, DATA_OE}
  logic [5:0] strb;
  assign strb = {ROM_CE_n, ROM_OE_n, ROM_WE_n, ROM_BHE_n, ROM_BLE_n, ROM_DATA_OE};
  localparam logic [5:0] S_IDLE     = 6'b111110;
  localparam logic [5:0] S_RD       = 6'b001000;
  localparam logic [5:0] S_WR_HI    = 6'b011011;
  localparam logic [5:0] S_WR_HI_WE = 6'b010011;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_s;

  rom_arbiter dut (
    .CLK (CLK), .RST (RST),
    .snes_rd_start (snes_rd_start), .snes_wr_start (snes_wr_start),
    .snes_addr (snes_addr), .snes_hit (snes_hit),
    .snes_writable (snes_writable), .snes_wr_data (snes_wr_data),
    .snes_rd_data (snes_rd_data), .snes_rd_valid (snes_rd_valid),
    .mcu_req (mcu_req), .mcu_we (mcu_we), .mcu_addr (mcu_addr),
    .mcu_wr_data (mcu_wr_data), .mcu_ack (mcu_ack),
    .mcu_rd_data (mcu_rd_data), .mcu_addr_cur (mcu_addr_cur),
    .ROM_ADDR (ROM_ADDR), .ROM_DATA_OUT (ROM_DATA_OUT),
    .ROM_DATA_IN (ROM_DATA_IN), .ROM_DATA_OE (ROM_DATA_OE),
    .ROM_CE_n (ROM_CE_n), .ROM_OE_n (ROM_OE_n), .ROM_WE_n (ROM_WE_n),
    .ROM_BHE_n (ROM_BHE_n), .ROM_BLE_n (ROM_BLE_n),
    .state_dbg (state_dbg)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    snes_rd_start = 1'b0; snes_wr_start = 1'b0;
    snes_addr = '0; snes_hit = 1'b0; snes_writable = 1'b0; snes_wr_data = '0;
    mcu_req = 1'b0; mcu_we = 1'b0; mcu_addr = '0; mcu_wr_data = '0;
    ROM_DATA_IN = 16'hBEEF;
    step();
    step();
    RST = 1'b0;

    // ---- reset state
    chk("rst_strobes", 32'(strb), 32'(S_IDLE));
    chk("rst_addr", 32'(ROM_ADDR), 32'h0);
    chk("rst_valid", 32'(snes_rd_valid), 32'h0);
    chk("rst_ack", 32'(mcu_ack), 32'h0);
    chk("rst_snes_data", 32'(snes_rd_data), 32'h0);
    chk("rst_mcu_data", 32'(mcu_rd_data), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // ---- SNES read 0x000124 -> word 0x92, lower byte 0xEF, valid at +7
    snes_rd_start = 1'b1; snes_addr = 24'h000124; snes_hit = 1'b1;
    step();
    snes_rd_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      chk("rd1_strobes", 32'(strb), 32'(S_RD));
      chk("rd1_addr", 32'(ROM_ADDR), 32'h000092);
      chk("rd1_valid_early", 32'(snes_rd_valid), 32'h0);
      step();
    end
    chk("rd1_valid", 32'(snes_rd_valid), 32'h1);
    chk("rd1_data", 32'(snes_rd_data), 32'hEF);
    chk("rd1_gap_strobes", 32'(strb), 32'(S_IDLE));
    step();
    chk("rd1_valid_pulse", 32'(snes_rd_valid), 32'h0);
    chk("rd1_data_held", 32'(snes_rd_data), 32'hEF);

    // ---- SNES write 0xE00001 upper lane, WE_n low window cycles 2..4
    snes_wr_start = 1'b1; snes_addr = 24'hE00001; snes_writable = 1'b1;
    snes_wr_data = 8'h5A;
    step();
    snes_wr_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      exp_s = (i >= 2 && i <= 4) ? S_WR_HI_WE : S_WR_HI;
      chk("wr1_strobes", 32'(strb), 32'(exp_s));
      chk("wr1_dout", 32'(ROM_DATA_OUT), 32'h5A5A);
      chk("wr1_addr", 32'(ROM_ADDR), 32'h700000);
      step();
    end
    chk("wr1_no_valid", 32'(snes_rd_valid), 32'h0);
    chk("wr1_gap_strobes", 32'(strb), 32'(S_IDLE));
    step();

    // ---- write with writable=0 is ignored
    snes_wr_start = 1'b1; snes_addr = 24'h000200; snes_writable = 1'b0;
    step();
    snes_wr_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_ro_ce", 32'(ROM_CE_n), 32'h1);
      step();
    end

    // ---- SNES read and MCU read in the same cycle: SNES first, 1 gap, MCU
    snes_rd_start = 1'b1; snes_addr = 24'h000124;
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 24'h000010;
    step();
    snes_rd_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      chk("arb_snes_addr", 32'(ROM_ADDR), 32'h000092);
      chk("arb_no_ack", 32'(mcu_ack), 32'h0);
      step();
    end
    chk("arb_snes_valid", 32'(snes_rd_valid), 32'h1);
    chk("arb_gap", 32'(strb), 32'(S_IDLE));
    ROM_DATA_IN = 16'h1234;
    step();
    for (int i = 1; i <= 6; i++) begin
      chk("arb_mcu_strobes", 32'(strb), 32'(S_RD));
      chk("arb_mcu_addr", 32'(ROM_ADDR), 32'h000008);
      chk("arb_mcu_no_ack", 32'(mcu_ack), 32'h0);
      step();
    end
    chk("arb_mcu_ack", 32'(mcu_ack), 32'h1);
    chk("arb_mcu_data", 32'(mcu_rd_data), 32'h34);
    // request still high in the ack cycle must not restart
    step();
    mcu_req = 1'b0;
    chk("arb_no_restart", 32'(strb), 32'(S_IDLE));
    chk("arb_ack_pulse", 32'(mcu_ack), 32'h0);
    step();
    chk("arb_idle", 32'(state_dbg), 32'(ST_IDLE));

    // ---- SNES start 2 cycles into an MCU write; MCU finishes, then SNES
    mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 24'h000021; mcu_wr_data = 8'hC3;
    ROM_DATA_IN = 16'h77AA;
    step();
    for (int i = 1; i <= 5; i++) begin
      exp_s = (i >= 2 && i <= 4) ? S_WR_HI_WE : S_WR_HI;
      chk("mwr_strobes", 32'(strb), 32'(exp_s));
      chk("mwr_addr", 32'(ROM_ADDR), 32'h000010);
      chk("mwr_dout", 32'(ROM_DATA_OUT), 32'hC3C3);
      if (i == 2) begin
        snes_rd_start = 1'b1; snes_addr = 24'h000124;
      end
      step();
      snes_rd_start = 1'b0;
    end
    chk("mwr_ack", 32'(mcu_ack), 32'h1);
    chk("mwr_gap", 32'(strb), 32'(S_IDLE));
    chk("mcu_addr_cur_mirror", 32'(mcu_addr_cur), 32'h000021);
    step();
    mcu_req = 1'b0;
    chk("mwr_snes_next", 32'(strb), 32'(S_RD));
    chk("mwr_snes_addr", 32'(ROM_ADDR), 32'h000092);
    for (int i = 0; i < 6; i++) step();
    chk("mwr_snes_valid", 32'(snes_rd_valid), 32'h1);
    chk("mwr_snes_data", 32'(snes_rd_data), 32'hAA);
    step();

    // ---- reset in cycle 3 of a SNES read aborts it silently
    snes_rd_start = 1'b1; snes_addr = 24'h000125; ROM_DATA_IN = 16'h4455;
    step();
    snes_rd_start = 1'b0;
    step();
    step();
    chk("abort_in_window", 32'(strb), 32'(S_RD));
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_strobes", 32'(strb), 32'(S_IDLE));
    chk("abort_addr", 32'(ROM_ADDR), 32'h0);
    chk("abort_data_clr", 32'(snes_rd_data), 32'h0);
    chk("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    for (int i = 0; i < 7; i++) begin
      chk("abort_no_valid", 32'(snes_rd_valid), 32'h0);
      step();
    end

    // ---- newer SNES start overwrites an unserved pending one
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 24'h000040;
    step();
    for (int i = 1; i <= 6; i++) begin
      if (i == 2) begin
        snes_rd_start = 1'b1; snes_addr = 24'h000300;
      end else if (i == 3) begin
        snes_rd_start = 1'b1; snes_addr = 24'h000302;
      end
      step();
      snes_rd_start = 1'b0;
    end
    chk("ovr_mcu_ack", 32'(mcu_ack), 32'h1);
    step();
    mcu_req = 1'b0;
    chk("ovr_snes_addr", 32'(ROM_ADDR), 32'h000181);
    for (int i = 0; i < 6; i++) step();
    chk("ovr_valid", 32'(snes_rd_valid), 32'h1);
    step();
    chk("ovr_single_window", 32'(strb), 32'(S_IDLE));
    step();
    chk("ovr_idle", 32'(state_dbg), 32'(ST_IDLE));

`ifdef ROM_ARB_MCU_AUTOINC_EN
    // ---- auto-increment stream from 0xFFFFFF with mcu_addr held
    ROM_DATA_IN = 16'hA1B2;
    mcu_addr = 24'hFFFFFF; mcu_we = 1'b0;
    for (int n = 0; n < 3; n++) begin
      mcu_req = 1'b1;
      step();
      chk("ainc_addr", 32'(ROM_ADDR), (n == 0) ? 32'h7FFFFF : 32'h0);
      for (int i = 0; i < 6; i++) step();
      chk("ainc_ack", 32'(mcu_ack), 32'h1);
      chk("ainc_data", 32'(mcu_rd_data), (n == 1) ? 32'hB2 : 32'hA1);
      step();
      mcu_req = 1'b0;
      step();
    end
    chk("ainc_cur", 32'(mcu_addr_cur), 32'h000002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
